shift_counter_nmode: RTL and testbench

//  Parametrised twisted-ring (Johnson) / ring shift counter, the successor to the fixed-width Johnson counter.

---
 rtl/shift_counter_nmode_pkg.sv | 22 ++
 rtl/shift_counter_nmode_if.sv | 26 ++
 rtl/shift_state_decode.sv | 51 +++++
 rtl/shift_counter_nmode.sv | 82 ++++++++
 tb/tb_shift_counter_nmode.sv | 136 +++++++++++++
 5 files changed

// File: rtl/shift_counter_nmode_pkg.sv
// Shared constants and helpers for the Johnson / ring shift counter family.
// Mode selectors, direction encoding, home-state and index-width helpers.
package shift_counter_nmode_pkg;

  localparam int MODE_JOHNSON = 0;
  localparam int MODE_RING    = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Home state only ever has bit 0 set (ring) or nothing set (Johnson).
  function automatic logic home_lsb(int ring);
    return (ring == MODE_RING);
  endfunction

  function automatic int calc_iw(int modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/shift_counter_nmode_if.sv
// Control and status bundle of the shift counter.
// The master drives control inputs; the slave (counter) returns its state.
interface shift_counter_nmode_if
  import shift_counter_nmode_pkg::*;
#(
  parameter int N    = 4,
  parameter int RING = MODE_JOHNSON
);
  localparam int MOD = (RING == MODE_RING) ? N : 2 * N;
  localparam int IW  = calc_iw(MOD);

  logic           en;
  logic           dir;
  logic           load;
  logic [N-1:0]   d;
  logic [N-1:0]   q;
  logic [IW-1:0]  idx;
  logic [MOD-1:0] dec;
  logic           tc;
  logic           load_err;

  modport master (output en, dir, load, d,
                  input  q, idx, dec, tc, load_err);
  modport slave  (input  en, dir, load, d,
                  output q, idx, dec, tc, load_err);
endinterface

// File: rtl/shift_state_decode.sv
// Combinational decode of a shift-counter pattern: legality, binary index
// and one-hot position. Used on the live state and on the load pattern.
module shift_state_decode
  import shift_counter_nmode_pkg::*;
#(
  parameter int N    = 4,
  parameter int RING = MODE_JOHNSON,
  localparam int MOD = (RING == MODE_RING) ? N : 2 * N,
  localparam int IW  = calc_iw(MOD)
) (
  input  logic [N-1:0]   q,
  output logic           legal,
  output logic [IW-1:0]  idx,
  output logic [MOD-1:0] dec
);

  int pop;
  int trans;
  int pos;
  int idx_int;

  always_comb begin
    pop     = 0;
    trans   = 0;
    pos     = 0;
    idx_int = 0;
    for (int i = 0; i < N; i++) begin
      pop = pop + int'(q[i]);
      if (q[i]) pos = i;
    end
    for (int i = 0; i < N - 1; i++) begin
      if (q[i] != q[i+1]) trans = trans + 1;
    end
    if (RING == MODE_RING) begin
      legal   = (pop == 1);
      idx_int = pos;
    end else begin
      // Johnson: filling phase counts ones, draining phase counts down from 2N.
      legal = (trans <= 1);
      if (q[0])          idx_int = pop;
      else if (pop == 0) idx_int = 0;
      else               idx_int = 2 * N - pop;
    end
    idx = IW'(idx_int);
  end

  for (genvar gi = 0; gi < MOD; gi++) begin : g_dec
    assign dec[gi] = (idx == IW'(gi));
  end

endmodule

// File: rtl/shift_counter_nmode.sv
// Parametrised Johnson / ring shift counter with enable, direction,
// legality-checked load, binary index, one-hot decode and terminal count.
module shift_counter_nmode
  import shift_counter_nmode_pkg::*;
#(
  parameter int N    = 4,
  parameter int RING = MODE_JOHNSON
) (
  input  logic                 clk,
  input  logic                 clr,
  shift_counter_nmode_if.slave bus
);

  localparam int MOD = (RING == MODE_RING) ? N : 2 * N;
  localparam int IW  = calc_iw(MOD);
  localparam logic [N-1:0] HOME = {{(N-1){1'b0}}, home_lsb(RING)};

  logic [N-1:0]   q_q, q_d;
  logic           load_err_q, load_err_d;
  logic           q_legal, d_legal;
  logic [IW-1:0]  q_idx;
  logic [MOD-1:0] q_dec;
  logic [IW-1:0]  unused_d_idx;
  logic [MOD-1:0] unused_d_dec;

  shift_state_decode #(.N(N), .RING(RING)) u_dec_q (
    .q     (q_q),
    .legal (q_legal),
    .idx   (q_idx),
    .dec   (q_dec)
  );

  shift_state_decode #(.N(N), .RING(RING)) u_dec_d (
    .q     (bus.d),
    .legal (d_legal),
    .idx   (unused_d_idx),
    .dec   (unused_d_dec)
  );

  always_comb begin
    q_d        = q_q;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (d_legal) begin
        q_d = bus.d;
      end else begin
        q_d        = HOME;
        load_err_d = 1'b1;
      end
    end else if (!q_legal) begin
      // Upset recovery: an illegal state never propagates past one edge.
      q_d = HOME;
    end else if (bus.en) begin
      if (RING == MODE_RING) begin
        if (bus.dir == DIR_UP) q_d = {q_q[N-2:0], q_q[N-1]};
        else                   q_d = {q_q[0], q_q[N-1:1]};
      end else begin
        if (bus.dir == DIR_UP) q_d = {q_q[N-2:0], ~q_q[N-1]};
        else                   q_d = {~q_q[0], q_q[N-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q        <= HOME;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.idx      = q_idx;
  assign bus.dec      = q_dec;
  assign bus.load_err = load_err_q;
  assign bus.tc       = bus.en & ~bus.load &
                        ((bus.dir & (q_idx == IW'(MOD - 1))) |
                         (~bus.dir & (q_idx == '0)));

endmodule

// File: tb/tb_shift_counter_nmode.sv
// Directed bench for the shift counter: one Johnson and one ring instance,
// expectations queued at drive time and popped after the clock edge.
module tb_shift_counter_nmode;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    int         idx;
    logic       lerr;
  } exp_t;

  exp_t sb[$];

  shift_counter_nmode_if #(.N(4), .RING(0)) ij ();
  shift_counter_nmode_if #(.N(4), .RING(1)) ir ();

  shift_counter_nmode #(.N(4), .RING(0)) dut_j (.clk(clk), .clr(clr), .bus(ij));
  shift_counter_nmode #(.N(4), .RING(1)) dut_r (.clk(clk), .clr(clr), .bus(ir));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ring, input bit en, input bit dir, input bit load,
                       input logic [3:0] d);
    if (ring) begin
      ir.en = en; ir.dir = dir; ir.load = load; ir.d = d;
    end else begin
      ij.en = en; ij.dir = dir; ij.load = load; ij.d = d;
    end
  endtask

  task automatic step(input string tag, input bit ring, input bit en, input bit dir,
                      input bit load, input logic [3:0] d, input bit exp_tc,
                      input logic [3:0] exp_q, input int exp_idx, input bit exp_lerr);
    exp_t e;
    logic [31:0] oq, oidx, odec, olerr, otc;
    @(negedge clk);
    drive(ring, en, dir, load, d);
    #1;
    otc = ring ? 32'(ir.tc) : 32'(ij.tc);
    chk({tag, " tc"}, otc, 32'(exp_tc));
    e.tag = tag; e.q = {4'b0, exp_q}; e.idx = exp_idx; e.lerr = exp_lerr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    oq    = ring ? 32'(ir.q)        : 32'(ij.q);
    oidx  = ring ? 32'(ir.idx)      : 32'(ij.idx);
    odec  = ring ? 32'(ir.dec)      : 32'(ij.dec);
    olerr = ring ? 32'(ir.load_err) : 32'(ij.load_err);
    chk({e.tag, " q"}, oq, 32'(e.q));
    chk({e.tag, " idx"}, oidx, 32'(e.idx));
    chk({e.tag, " dec"}, odec, 32'(1) << e.idx);
    chk({e.tag, " load_err"}, olerr, 32'(e.lerr));
    $display("step %-10s ring=%0d en=%0d dir=%0d load=%0d d=%b -> q=%b idx=%0d load_err=%0d",
             e.tag, ring, en, dir, load, d, oq[3:0], oidx, olerr);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    #1 clr = 1'b1;
    #3;
    chk("rst j q", 32'(ij.q), 32'h0);
    chk("rst j idx", 32'(ij.idx), 32'h0);
    chk("rst j dec", 32'(ij.dec), 32'h1);
    chk("rst j load_err", 32'(ij.load_err), 32'h0);
    chk("rst r q", 32'(ir.q), 32'h1);
    chk("rst r idx", 32'(ir.idx), 32'h0);
    chk("rst r dec", 32'(ir.dec), 32'h1);
    chk("rst r load_err", 32'(ir.load_err), 32'h0);
    @(negedge clk);
    #2 clr = 1'b0;

    // Johnson count up through a full wrap
    step("j_up1", 0, 1, 1, 0, 4'b0000, 0, 4'b0001, 1, 0);
    step("j_up2", 0, 1, 1, 0, 4'b0000, 0, 4'b0011, 2, 0);
    step("j_up3", 0, 1, 1, 0, 4'b0000, 0, 4'b0111, 3, 0);
    step("j_up4", 0, 1, 1, 0, 4'b0000, 0, 4'b1111, 4, 0);
    step("j_up5", 0, 1, 1, 0, 4'b0000, 0, 4'b1110, 5, 0);
    step("j_up6", 0, 1, 1, 0, 4'b0000, 0, 4'b1100, 6, 0);
    step("j_up7", 0, 1, 1, 0, 4'b0000, 0, 4'b1000, 7, 0);
    step("j_up8", 0, 1, 1, 0, 4'b0000, 1, 4'b0000, 0, 0);

    // Johnson count down from home
    step("j_dn1", 0, 1, 0, 0, 4'b0000, 1, 4'b1000, 7, 0);
    step("j_dn2", 0, 1, 0, 0, 4'b0000, 0, 4'b1100, 6, 0);
    step("j_dn3", 0, 1, 0, 0, 4'b0000, 0, 4'b1110, 5, 0);

    // Loads: legal, illegal, then error pulse clears
    step("j_ld1100", 0, 0, 1, 1, 4'b1100, 0, 4'b1100, 6, 0);
    step("j_ld0101", 0, 0, 1, 1, 4'b0101, 0, 4'b0000, 0, 1);
    step("j_idle", 0, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0);

    // Load wins over enable, then hold
    step("j_ld_en", 0, 1, 1, 1, 4'b0011, 0, 4'b0011, 2, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("j_hold%0d", i), 0, 0, 1, 0, 4'b0000, 0, 4'b0011, 2, 0);

    // Asynchronous clear mid-count
    step("j_cnt", 0, 1, 1, 0, 4'b0000, 0, 4'b0111, 3, 0);
    #1 clr = 1'b1;
    #1;
    chk("clr async q", 32'(ij.q), 32'h0);
    chk("clr async idx", 32'(ij.idx), 32'h0);
    chk("clr async dec", 32'(ij.dec), 32'h1);
    $display("step clr_pulse  q=%b idx=%0d", ij.q, ij.idx);
    #1 clr = 1'b0;
    step("j_resume", 0, 1, 1, 0, 4'b0000, 0, 4'b0001, 1, 0);

    // Ring count up, illegal load, down wrap
    step("r_up1", 1, 1, 1, 0, 4'b0000, 0, 4'b0010, 1, 0);
    step("r_up2", 1, 1, 1, 0, 4'b0000, 0, 4'b0100, 2, 0);
    step("r_up3", 1, 1, 1, 0, 4'b0000, 0, 4'b1000, 3, 0);
    step("r_up4", 1, 1, 1, 0, 4'b0000, 1, 4'b0001, 0, 0);
    step("r_ld0110", 1, 1, 1, 1, 4'b0110, 0, 4'b0001, 0, 1);
    step("r_dn1", 1, 1, 0, 0, 4'b0000, 1, 4'b1000, 3, 0);
    step("r_ld0100", 1, 0, 0, 1, 4'b0100, 0, 4'b0100, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
